regfile_mp: RTL
===============

Name: regfile_mp

Overview:
Parametrised successor to the single-write, two-read processor register file. Three read ports (Rn, Rm, Rs for register-shifted operands) and two write ports (ALU result and load/base writeback). Optional same-cycle write-to-read bypass. Per-register pending scoreboard so the control unit can stall on outstanding producers. Sits between decode and writeback in the pipelined core.

Parameters:
WIDTH, 32, data width of every register and data port
ADDR_W, 4, register index width; NREG = 2**ADDR_W registers
BYPASS, 1, 1 = a write in the current cycle is forwarded to matching read ports combinationally; 0 = reads return stored value only

Ports:
CLK  in  1  clock, all state updates on rising edge
RESETn  in  1  asynchronous reset, active low
RA1  in  ADDR_W  read index 1
RA2  in  ADDR_W  read index 2
RA3  in  ADDR_W  read index 3
WE1  in  1  write enable port 1, active high
WA1  in  ADDR_W  write index port 1
WD1  in  WIDTH  write data port 1
WE2  in  1  write enable port 2, active high
WA2  in  ADDR_W  write index port 2
WD2  in  WIDTH  write data port 2
R15  in  WIDTH  PC value supplied for reads of index NREG-1
ISSUE  in  1  mark register IA pending at next edge
IA  in  ADDR_W  index being issued as destination
RD1  out  WIDTH  read data 1
RD2  out  WIDTH  read data 2
RD3  out  WIDTH  read data 3
PEND1  out  1  RA1 has an outstanding producer
PEND2  out  1  RA2 has an outstanding producer
PEND3  out  1  RA3 has an outstanding producer

Behaviour:
- Reset (RESETn=0, async, effective immediately including mid-cycle): all NREG-1 storage registers = 0, all pending bits = 0. Reads remain combinational during reset: RDn = 0, or R15 if RAn = NREG-1; PENDn = 0.
- Index NREG-1 (PC) has no storage: reads return R15 unconditionally, never bypassed, never pending; writes and ISSUE to it are ignored.
- Writes: at rising CLK, if WEx=1 and WAx != NREG-1, reg[WAx] <= WDx. Both ports enabled and WA1 = WA2: port 2 wins.
- Reads: combinational, zero latency. BYPASS=0: RDn = reg[RAn]. BYPASS=1: if WE2 & WA2 = RAn → WD2; else if WE1 & WA1 = RAn → WD1; else reg[RAn]. Port 2 takes priority, matching write priority.
- Scoreboard: pending[i] set at edge when ISSUE=1 and IA=i; cleared at edge when either write port writes i. ISSUE and a write to the same index in one cycle: set wins (new producer supersedes the retiring one). ISSUE to an already-pending register keeps it pending.
- PENDn = pending[RAn]. With BYPASS=1, PENDn is forced 0 when a write to RAn is present this cycle (value available via bypass). With BYPASS=0, PENDn follows stored pending bit only.
- No internal counters saturate or wrap; all indices are full-range, no out-of-range case exists.

Test Plan:
- Reset: RESETn=0 with RA1=3, RA2=15, R15=0x00000001 → RD1=0, RD2=0x00000001, PEND1..3=0; release, read all 15 regs → all 0.
- Dual write: cycle k WE1=1 WA1=2 WD1=0xAAAA0000, WE2=1 WA2=5 WD2=0x5555; next cycle RA1=2 RA2=5 → RD1=0xAAAA0000, RD2=0x5555. Same index WA1=WA2=7, WD1=1, WD2=2 → reg7=2.
- Bypass: BYPASS=1, WE1=1 WA1=4 WD1=0x1234, RA3=4 same cycle → RD3=0x1234 before edge. BYPASS=0 same stimulus → RD3=old value, 0x1234 after edge.
- PC: WE1=1 WA1=15 WD1=0xDEAD, R15 stepped 0x1→0x2 → RD with RA=15 tracks R15, never 0xDEAD; ISSUE IA=15 → PEND stays 0.
- Scoreboard: ISSUE IA=6, edge → PEND1=1 (RA1=6); WE2 WA2=6 in a later cycle → PEND1=0 that cycle (BYPASS=1), pending cleared after edge; ISSUE IA=6 together with WE1 WA1=6 → pending remains 1.
- Async reset mid-operation: assert RESETn=0 between edges with pending[6]=1, reg6=0x77 → PEND and RD drop to 0 immediately, without waiting for an edge.

Source files
------------

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : multi-port processor register file with pending scoreboard.
//
// Three combinational read ports (Rn, Rm, Rs) and two write ports (ALU result
// and load/base writeback). The highest index (NREG-1) is the PC. It has no
// storage, and reads of it return the R15 input. An optional bypass forwards
// same-cycle writes to matching read ports. A per-register pending bit records
// issued destinations whose producer has not yet written back.
//
// Ports:
//   CLK, RESETn          clock (rising edge), asynchronous active-low reset
//   RA1..RA3             read indices
//   RD1..RD3             read data (combinational)
//   PEND1..PEND3         read index has an outstanding producer
//   WE1/WA1/WD1          write port 1 (ALU result)
//   WE2/WA2/WD2          write port 2 (load/base writeback); wins over port 1
//   R15                  PC value returned for reads of index NREG-1
//   ISSUE/IA             mark register IA pending at the next edge
// ---------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 4,
    parameter int BYPASS = 1
) (
    input  logic              CLK,
    input  logic              RESETn,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] RA3,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] WA1,
    input  logic [WIDTH-1:0]  WD1,
    input  logic              WE2,
    input  logic [ADDR_W-1:0] WA2,
    input  logic [WIDTH-1:0]  WD2,
    input  logic [WIDTH-1:0]  R15,
    input  logic              ISSUE,
    input  logic [ADDR_W-1:0] IA,
    output logic [WIDTH-1:0]  RD1,
    output logic [WIDTH-1:0]  RD2,
    output logic [WIDTH-1:0]  RD3,
    output logic              PEND1,
    output logic              PEND2,
    output logic              PEND3
);

    localparam int                NREG   = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX = {ADDR_W{1'b1}};

    // The PC entry of the array is never written and stays at its reset
    // value, so it collapses to constants; reads of PC_IDX never reach it.
    logic [WIDTH-1:0]  regs_r [NREG];
    logic [NREG-1:0]   pend_r;
    logic [NREG-1:0]   pend_nxt_s;

    logic              wr1_s;
    logic              wr2_s;
    logic              byp_en_s;

    logic [ADDR_W-1:0] ra_s   [3];
    logic [WIDTH-1:0]  rd_s   [3];
    logic              pend_s [3];

    // Writes that target the PC index are discarded.
    assign wr1_s = WE1 && (WA1 != PC_IDX);
    assign wr2_s = WE2 && (WA2 != PC_IDX);

    // Forwarding is suppressed while in reset. This makes reads show the
    // cleared state immediately.
    assign byp_en_s = (BYPASS != 0) && RESETn;

    assign ra_s[0] = RA1;
    assign ra_s[1] = RA2;
    assign ra_s[2] = RA3;

    // Register storage: port 2 is applied last so it wins on an index clash.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= '0;
            end
        end else begin
            if (wr1_s) begin
                regs_r[WA1] <= WD1;
            end
            if (wr2_s) begin
                regs_r[WA2] <= WD2;
            end
        end
    end

    // Scoreboard next state: a fresh issue beats a retiring write.
    // The PC bit never becomes pending.
    always_comb begin
        pend_nxt_s = '0;
        for (int i = 0; i < NREG; i++) begin
            pend_nxt_s[i] = (ADDR_W'(i) != PC_IDX) &&
                            ((ISSUE && (IA == ADDR_W'(i))) ||
                             (pend_r[i] &&
                              !(wr1_s && (WA1 == ADDR_W'(i))) &&
                              !(wr2_s && (WA2 == ADDR_W'(i)))));
        end
    end

    // Scoreboard state register.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            pend_r <= '0;
        end else begin
            pend_r <= pend_nxt_s;
        end
    end

    // Read ports: PC first, then bypass (port 2 before port 1), then storage.
    // A bypassed value is available now, so its pending flag is masked.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            rd_s[p]   = '0;
            pend_s[p] = 1'b0;
            if (ra_s[p] == PC_IDX) begin
                rd_s[p]   = R15;
                pend_s[p] = 1'b0;
            end else if (byp_en_s && wr2_s && (WA2 == ra_s[p])) begin
                rd_s[p]   = WD2;
                pend_s[p] = 1'b0;
            end else if (byp_en_s && wr1_s && (WA1 == ra_s[p])) begin
                rd_s[p]   = WD1;
                pend_s[p] = 1'b0;
            end else begin
                rd_s[p]   = regs_r[ra_s[p]];
                pend_s[p] = pend_r[ra_s[p]];
            end
        end
    end

    assign RD1   = rd_s[0];
    assign RD2   = rd_s[1];
    assign RD3   = rd_s[2];
    assign PEND1 = pend_s[0];
    assign PEND2 = pend_s[1];
    assign PEND3 = pend_s[2];

endmodule
